// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (default 640x480@60) and helpers for the
// timing generator, pixel datapath and register block.
package vga_timing_pkg;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with carry out, plus blank and
// sync decodes registered from the next-state count.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ce,
    output cnt_t cnt,
    output logic carry,
    output logic blank,
    output logic blank_next,
    output logic sync_n
);

    localparam int unsigned TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    localparam cnt_t        LAST    = cnt_t'(TOTAL - 1);
    localparam int unsigned SYNC_LO = ACTIVE + FP;
    localparam int unsigned SYNC_HI = ACTIVE + FP + SYNC;

    cnt_t cnt_reg, cnt_next;
    logic blank_reg, sync_n_reg, sync_n_next;

    // Decodes compare in 32 bits so SYNC_HI == 1024 does not alias to 0.
    always_comb begin
        carry    = !clr && ce && (cnt_reg == LAST);
        cnt_next = cnt_reg;
        if (clr)
            cnt_next = '0;
        else if (ce)
            cnt_next = carry ? '0 : cnt_reg + 1'b1;
        blank_next  = clr || (32'(cnt_next) >= ACTIVE);
        sync_n_next = clr || !((32'(cnt_next) >= SYNC_LO) && (32'(cnt_next) < SYNC_HI));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            blank_reg  <= 1'b1;
            sync_n_reg <= 1'b1;
        end else begin
            cnt_reg    <= cnt_next;
            blank_reg  <= blank_next;
            sync_n_reg <= sync_n_next;
        end
    end

    assign cnt    = cnt_reg;
    assign blank  = blank_reg;
    assign sync_n = sync_n_reg;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider driving horizontal and
// vertical axis counters; all outputs registered from next-state counts.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vga_en,
    output logic       pix_ce,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hblank,
    output logic       vblank,
    output logic       disp_en,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_reg;
    logic             div_last;
    logic             pix_ce_reg, frame_start_reg, disp_en_reg;
    logic             h_carry, v_carry, h_blank_next, v_blank_next;

    assign div_last = (div_reg == DIV_W'(CLK_DIV - 1));

    // Disable acts as a synchronous clear that overrides any pending advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg         <= '0;
            pix_ce_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            disp_en_reg     <= 1'b0;
        end else if (!vga_en) begin
            div_reg         <= '0;
            pix_ce_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            disp_en_reg     <= 1'b0;
        end else begin
            div_reg         <= div_last ? '0 : div_reg + 1'b1;
            pix_ce_reg      <= div_last;
            frame_start_reg <= h_carry && v_carry;
            disp_en_reg     <= !h_blank_next && !v_blank_next;
        end
    end

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (!vga_en),
        .ce         (pix_ce_reg),
        .cnt        (hcnt),
        .carry      (h_carry),
        .blank      (hblank),
        .blank_next (h_blank_next),
        .sync_n     (hsync_n)
    );

    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (!vga_en),
        .ce         (h_carry),
        .cnt        (vcnt),
        .carry      (v_carry),
        .blank      (vblank),
        .blank_next (v_blank_next),
        .sync_n     (vsync_n)
    );

    assign pix_ce      = pix_ce_reg;
    assign frame_start = frame_start_reg;
    assign disp_en     = disp_en_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default, CLK_DIV=1 tiny, CLK_DIV=3 tiny)
// checked against an arithmetic model driven by enabled-cycle counts.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_big = 1'b0, en_small = 1'b0, en_mid = 1'b0;
    int   k_big = 0, k_small = 0, k_mid = 0;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    // Enabled-edge counts since the last enable; the model derives everything from these.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_big <= 0; k_small <= 0; k_mid <= 0;
        end else begin
            k_big   <= en_big   ? k_big + 1   : 0;
            k_small <= en_small ? k_small + 1 : 0;
            k_mid   <= en_mid   ? k_mid + 1   : 0;
        end
    end

    logic       b_pce, b_hb, b_vb, b_de, b_hs, b_vs, b_fs;
    logic [9:0] b_h, b_v;
    logic       s_pce, s_hb, s_vb, s_de, s_hs, s_vs, s_fs;
    logic [9:0] s_h, s_v;
    logic       m_pce, m_hb, m_vb, m_de, m_hs, m_vs, m_fs;
    logic [9:0] m_h, m_v;

    vga_timing dut_big (
        .clk(clk), .rst_n(rst_n), .vga_en(en_big), .pix_ce(b_pce), .hcnt(b_h), .vcnt(b_v),
        .hblank(b_hb), .vblank(b_vb), .disp_en(b_de), .hsync_n(b_hs), .vsync_n(b_vs),
        .frame_start(b_fs)
    );

    vga_timing #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .vga_en(en_small), .pix_ce(s_pce), .hcnt(s_h), .vcnt(s_v),
        .hblank(s_hb), .vblank(s_vb), .disp_en(s_de), .hsync_n(s_hs), .vsync_n(s_vs),
        .frame_start(s_fs)
    );

    vga_timing #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_mid (
        .clk(clk), .rst_n(rst_n), .vga_en(en_mid), .pix_ce(m_pce), .hcnt(m_h), .vcnt(m_v),
        .hblank(m_hb), .vblank(m_vb), .disp_en(m_de), .hsync_n(m_hs), .vsync_n(m_vs),
        .frame_start(m_fs)
    );

    wire [26:0] obs_big   = {b_pce, b_h, b_v, b_hb, b_vb, b_de, b_hs, b_vs, b_fs};
    wire [26:0] obs_small = {s_pce, s_h, s_v, s_hb, s_vb, s_de, s_hs, s_vs, s_fs};
    wire [26:0] obs_mid   = {m_pce, m_h, m_v, m_hb, m_vb, m_de, m_hs, m_vs, m_fs};

    // After k enabled edges: n = (k-1)/d pixel advances have taken effect.
    function automatic logic [26:0] model(input int k, input int d,
                                          input int ha, input int hf, input int hs, input int hbp,
                                          input int va, input int vf, input int vs, input int vbp);
        int n, ht, vt, h, v;
        logic pce, hbl, vbl, hsn, vsn, fs;
        if (k == 0)
            return {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ht  = ha + hf + hs + hbp;
        vt  = va + vf + vs + vbp;
        n   = (k - 1) / d;
        h   = n % ht;
        v   = (n / ht) % vt;
        pce = (k % d) == 0;
        hbl = h >= ha;
        vbl = v >= va;
        hsn = !(h >= ha + hf && h < ha + hf + hs);
        vsn = !(v >= va + vf && v < va + vf + vs);
        fs  = (n > 0) && ((k - 1) % d == 0) && (n % (ht * vt) == 0);
        return {pce, 10'(h), 10'(v), hbl, vbl, !hbl && !vbl, hsn, vsn, fs};
    endfunction

    function automatic logic [26:0] exp_big(input int k);
        return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic logic [26:0] exp_small(input int k);
        return model(k, 1, 8, 2, 2, 2, 4, 1, 1, 1);
    endfunction
    function automatic logic [26:0] exp_mid(input int k);
        return model(k, 3, 8, 2, 2, 2, 4, 1, 1, 1);
    endfunction

    task automatic test_reset();
        logic [26:0] idle;
        idle = exp_big(0);
        rst_n = 1'b0;
        en_big = 1'b1; en_small = 1'b1; en_mid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_big !== idle || obs_small !== idle || obs_mid !== idle) begin
                failures++;
                $display("FAIL reset_held: big=%h small=%h mid=%h expected=%h", obs_big, obs_small, obs_mid, idle);
            end
        end
        en_big = 1'b0; en_small = 1'b0; en_mid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (obs_big !== idle || obs_small !== idle || obs_mid !== idle) begin
                failures++;
                $display("FAIL idle_disabled: cyc=%0d big=%h small=%h mid=%h expected=%h", i, obs_big, obs_small, obs_mid, idle);
            end
        end
    endtask

    // Two full default lines: pixel rate, active/blank edge, hsync window, line wrap.
    task automatic test_pixel_rate();
        int first_ce;
        first_ce = -1;
        en_big = 1'b1;
        for (int i = 1; i <= 6500; i++) begin
            @(negedge clk);
            if (first_ce < 0 && b_pce) first_ce = i;
            checks++;
            if (obs_big !== exp_big(k_big)) begin
                failures++;
                if (failures < 40)
                    $display("FAIL line_model: k=%0d got=%h expected=%h", k_big, obs_big, exp_big(k_big));
            end
        end
        checks++;
        if (first_ce != 4) begin
            failures++;
            $display("FAIL first_pix_ce: got clk %0d expected clk 4", first_ce);
        end
    endtask

    task automatic test_disable_mid();
        int guard, first_ce;
        guard = 0;
        while (b_h != 10'd300 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 4000) begin
            failures++;
            $display("FAIL reach_hcnt300: timed out hcnt=%0d", b_h);
        end
        en_big = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_big !== exp_big(0)) begin
            failures++;
            $display("FAIL disable_idle: got=%h expected=%h", obs_big, exp_big(0));
        end
        en_big = 1'b1;
        first_ce = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (first_ce < 0 && b_pce) first_ce = i;
            checks++;
            if (obs_big !== exp_big(k_big)) begin
                failures++;
                $display("FAIL reenable_model: k=%0d got=%h expected=%h", k_big, obs_big, exp_big(k_big));
            end
        end
        checks++;
        if (first_ce != 4) begin
            failures++;
            $display("FAIL reenable_first_ce: got clk %0d expected clk 4", first_ce);
        end
        en_big = 1'b0;
    endtask

    // Tiny raster at CLK_DIV=1: three frames, frame_start spacing of 14*7 clks.
    task automatic test_frame_small();
        int last_fs, n_fs;
        last_fs = -1; n_fs = 0;
        en_small = 1'b1;
        for (int i = 1; i <= 350; i++) begin
            @(negedge clk);
            checks++;
            if (obs_small !== exp_small(k_small)) begin
                failures++;
                $display("FAIL small_model: k=%0d got=%h expected=%h", k_small, obs_small, exp_small(k_small));
            end
            if (s_fs) begin
                n_fs++;
                checks++;
                if ((last_fs < 0 && i != 99) || (last_fs >= 0 && i - last_fs != 98)) begin
                    failures++;
                    $display("FAIL frame_period: clk=%0d previous=%0d expected spacing 98 (first at 99)", i, last_fs);
                end
                last_fs = i;
            end
        end
        checks++;
        if (n_fs != 3) begin
            failures++;
            $display("FAIL frame_count: got %0d expected 3", n_fs);
        end
        en_small = 1'b0;
    endtask

    // Random enable toggling on both tiny rasters, including flips on pix_ce edges.
    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (obs_small !== exp_small(k_small) || obs_mid !== exp_mid(k_mid)) begin
                failures++;
                if (failures < 40)
                    $display("FAIL random_model: ks=%0d small=%h exp=%h km=%0d mid=%h exp=%h",
                             k_small, obs_small, exp_small(k_small), k_mid, obs_mid, exp_mid(k_mid));
            end
            if ($urandom_range(0, 199) == 0) en_small = ~en_small;
            if ($urandom_range(0, 149) == 0 || (m_pce && $urandom_range(0, 99) == 0)) en_mid = ~en_mid;
            if (i < 5) begin en_small = 1'b1; en_mid = 1'b1; end
        end
        en_small = 1'b0; en_mid = 1'b0;
    endtask

    task automatic test_async_reset();
        en_big = 1'b1; en_mid = 1'b1;
        repeat ($urandom_range(50, 300)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_big !== exp_big(0) || obs_mid !== exp_mid(0)) begin
            failures++;
            $display("FAIL async_reset: big=%h mid=%h expected=%h", obs_big, obs_mid, exp_big(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (obs_big !== exp_big(k_big) || obs_mid !== exp_mid(k_mid)) begin
                failures++;
                $display("FAIL post_reset_model: big=%h exp=%h mid=%h exp=%h",
                         obs_big, exp_big(k_big), obs_mid, exp_mid(k_mid));
            end
        end
        en_big = 1'b0; en_mid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pixel_rate();
        test_disable_mid();
        test_frame_small();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
VGA raster timing generator; the functional-side counterpart of the VGA register block.
- Consumes the register block's `vga_en` enable.
- Produces the `vblank`/`hblank` status the register block samples, plus sync, active-video and pixel-coordinate outputs for the pixel datapath.
- Default timing is 640x480@60 from a system clock divided down to the pixel rate.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1); pix_ce period
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  global clock
rst_n  in  1  global reset; asynchronous, active-low
vga_en  in  1  module enable from the VGA register block
pix_ce  out  1  one-clk pixel-rate enable strobe
hcnt  out  10  current pixel column, 0..H_TOTAL-1
vcnt  out  10  current line, 0..V_TOTAL-1
hblank  out  1  1 when hcnt >= H_ACTIVE, or when disabled
vblank  out  1  1 when vcnt >= V_ACTIVE, or when disabled
disp_en  out  1  active video: !hblank & !vblank
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low
frame_start  out  1  one-clk pulse when (hcnt,vcnt) wraps to (0,0)

Behaviour:
- Derived constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 and 525.
- Legal range: both totals <= 1024 (10-bit counters). Violation is a parameter error, not handled in RTL.
- Reset values (async on rst_n low):
  - divider = 0, hcnt = 0, vcnt = 0
  - pix_ce = 0, frame_start = 0, disp_en = 0
  - hblank = 1, vblank = 1
  - hsync_n = 1, vsync_n = 1
- Disabled (vga_en = 0): on each clk edge, force the reset values above. Status reads as blank; syncs are deasserted.
- Divider:
  - Counts 0..CLK_DIV-1 while enabled.
  - pix_ce is registered; it is 1 for the single clk after the divider reaches CLK_DIV-1.
  - First pix_ce is CLK_DIV clks after vga_en is first sampled high.
  - CLK_DIV = 1: pix_ce is high every enabled clk, starting 1 clk after enable.
- Counters:
  - Advance only on the clk edge where pix_ce is high.
  - hcnt: H_TOTAL-1 wraps to 0 and increments vcnt.
  - vcnt: V_TOTAL-1 wraps to 0.
- Output timing:
  - All outputs are registered and decoded from the next-state counts. Decodes are therefore consistent with hcnt/vcnt in the same cycle, with no extra latency.
  - hsync_n = 0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync_n = 0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC. It changes with vcnt, i.e. at hcnt = 0.
  - frame_start = 1 for exactly the clk in which hcnt = 0 and vcnt = 0 become valid after a wrap. It is not asserted on the initial (0,0) after enable or reset.
- Boundary and abnormal cases:
  - vga_en falls mid-frame: idle values on the next clk edge; no frame completion.
  - vga_en rises again: restart from (0,0) with a fresh divider phase.
  - vga_en toggling on the same clk as pix_ce: enable wins priority; the counter advance is discarded.
  - rst_n asserted mid-line: immediate idle; no glitch requirements beyond that.

Decomposition:
- Shared header `vga_timing.vh`: default 640x480@60 constants, plus H_TOTAL/V_TOTAL localparams. Also usable by the pixel datapath and the register block.
- One sub-module, `vga_axis_cnt`, instantiated twice (horizontal, vertical). It holds a wrapping counter with a count enable, a wrap-carry output, and blank/sync decode parameterised by ACTIVE/FP/SYNC/BP.

Test Plan:
- Reset/idle: rst_n low, then vga_en = 0 for 100 clks -> hcnt = vcnt = 0, hblank = vblank = 1, hsync_n = vsync_n = 1, pix_ce = disp_en = frame_start = 0 throughout.
- Pixel rate: vga_en = 1, CLK_DIV = 4 -> first pix_ce 4 clks after enable, then every 4 clks. disp_en high on line 0 for 640 pix_ce; hblank rises when hcnt = 640.
- Horizontal sync: line 0 -> hsync_n low exactly for hcnt 656..751 (96 pixels). hcnt 799 wraps to 0 and vcnt becomes 1; line period 3200 clks.
- Vertical sync and frame: vblank rises at vcnt = 480; vsync_n low for vcnt 490..491. frame_start pulses once per frame, 1,680,000 clks apart (800*525*4); never at initial enable.
- Disable mid-frame: drop vga_en at hcnt = 300, vcnt = 200 -> next clk idle values. Re-enable -> restart at (0,0); first pix_ce after 4 clks.
- CLK_DIV = 1, small timing (H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2, V = 4/1/1/1) -> pix_ce continuous; frame_start every 14*7 = 98 clks; sync/blank windows match decode rules.
